// File: rtl/case_6_sdiv_11s_9s_11_seq.sv
// Sequential signed divider (restoring, radix-2 on magnitudes, then sign fix) with valid/ready on both sides.
// Optional remainder output enabled by defining CASE_6_SDIV_REM_EN.
module case_6_sdiv_11s_9s_11_seq #(
  parameter int unsigned ID         = 1,
  parameter int unsigned din0_WIDTH = 11,
  parameter int unsigned din1_WIDTH = 9,
  parameter int unsigned dout_WIDTH = 11
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  div_zero
`ifdef CASE_6_SDIV_REM_EN
  ,
  output logic [din1_WIDTH-1:0] rem
`endif
);

  // Magnitudes carry one extra bit so the most negative operand is exact.
  localparam int unsigned AW = din0_WIDTH + 1;
  localparam int unsigned BW = din1_WIDTH + 1;
  localparam int unsigned CW = $clog2(AW);

  if (ID == 0) begin : g_tag_zero
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   a_mag;
  logic [BW-1:0]   b_mag;
  logic [BW-1:0]   r;
  logic [AW-1:0]   q;
  logic            sa;
  logic            sb;
  logic            zero;

  logic [AW-1:0]         a_ext;
  logic [BW-1:0]         b_ext;
  logic [AW-1:0]         a_in;
  logic [BW-1:0]         b_in;
  logic [BW:0]           t;
  logic                  ge;
  logic [BW-1:0]         r_nxt;
  logic [dout_WIDTH-1:0] q_fix;

  // Operand magnitudes, one restoring step, and the signed quotient.
  always_comb begin
    a_ext = AW'($signed(din0));
    b_ext = BW'($signed(din1));
    a_in  = din0[din0_WIDTH-1] ? -a_ext : a_ext;
    b_in  = din1[din1_WIDTH-1] ? -b_ext : b_ext;
    t     = {r, a_mag[cnt]};
    ge    = (t >= {1'b0, b_mag});
    r_nxt = ge ? BW'(t - {1'b0, b_mag}) : BW'(t);
    q_fix = zero ? '1 : ((sa ^ sb) ? dout_WIDTH'(-q) : dout_WIDTH'(q));
  end

`ifdef CASE_6_SDIV_REM_EN
  logic [din1_WIDTH-1:0] rem_fix;

  // Remainder follows the dividend sign; a zero divisor passes the dividend through.
  always_comb begin
    rem_fix = zero ? din1_WIDTH'(sa ? -a_mag : a_mag)
                   : din1_WIDTH'(sa ? -r : r);
  end
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state    <= IDLE;
      in_rdy   <= 1'b1;
      out_vld  <= 1'b0;
      dout     <= '0;
      div_zero <= 1'b0;
      cnt      <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      r        <= '0;
      q        <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      zero     <= 1'b0;
`ifdef CASE_6_SDIV_REM_EN
      rem      <= '0;
`endif
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (in_vld) begin
            a_mag  <= a_in;
            b_mag  <= b_in;
            sa     <= din0[din0_WIDTH-1];
            sb     <= din1[din1_WIDTH-1];
            zero   <= (din1 == '0);
            cnt    <= CW'(AW - 1);
            r      <= '0;
            q      <= '0;
            in_rdy <= 1'b0;
            state  <= CALC;
            if (din1 != '0) begin
              div_zero <= 1'b0;
            end
          end
        end
        // One quotient bit per cycle, MSB of the magnitude first.
        CALC: begin
          r   <= r_nxt;
          q   <= {q[AW-2:0], ge};
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          dout     <= q_fix;
          div_zero <= zero;
`ifdef CASE_6_SDIV_REM_EN
          rem      <= rem_fix;
`endif
          out_vld  <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (out_rdy) begin
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
